// File: rtl/periodic_read_scheduler_if.sv
// rtl/periodic_read_scheduler_if.sv - periodic read injection handshake bundle
//
// Purpose: groups the scheduler-to-command-generator injection signals.
//   per_rd_req     scheduler -> banks   broadcast periodic read request
//   inject_select  scheduler -> banks   one-hot target bank
//   inject_open    scheduler -> banks   1 = open-row read, 0 = close read
//   inject_row     scheduler -> banks   row for an open-row read
//   per_rd_accept  banks -> scheduler   registered accept pulse per bank
// master: scheduler side.  slave: command generator side.
interface periodic_read_scheduler_if #(
  parameter int NUM_BANKS = 16,
  parameter int ROW_WIDTH = 18
);
  logic                 per_rd_req;
  logic [NUM_BANKS-1:0] inject_select;
  logic                 inject_open;
  logic [ROW_WIDTH-1:0] inject_row;
  logic [NUM_BANKS-1:0] per_rd_accept;

  modport master (
    output per_rd_req,
    output inject_select,
    output inject_open,
    output inject_row,
    input  per_rd_accept
  );

  modport slave (
    input  per_rd_req,
    input  inject_select,
    input  inject_open,
    input  inject_row,
    output per_rd_accept
  );
endinterface

// File: rtl/periodic_read_scheduler.sv
// rtl/periodic_read_scheduler.sv - periodic read injection sequencer
//
// Purpose: an interval timer triggers one periodic read at a time; banks are
// visited round-robin and each injection is a registered req/accept handshake.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   enable                  global enable for periodic reads
//   cfg_interval            cycles between injections, 0 = disabled
//   block_from_mc_refresh   freezes the interval countdown
//   bank_open_mask/row      per-bank open-row state (row slice b*ROW_WIDTH)
//   inj                     injection handshake (master modport)
//   sweep_done              pulse when the bank pointer wraps to 0
//   issued_count            saturating count of accepted injections
//   busy                    1 while not idle
//   timeout_err             timeout pulse (only with PER_RD_TIMEOUT_EN)
// Optional feature macro: PER_RD_TIMEOUT_EN
module periodic_read_scheduler #(
  parameter int NUM_BANKS      = 16,
  parameter int BANK_PTR_WIDTH = 4,
  parameter int ROW_WIDTH      = 18,
  parameter int INTERVAL_WIDTH = 16,
  parameter int CNT_WIDTH      = 16
`ifdef PER_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [INTERVAL_WIDTH-1:0]      cfg_interval,
  input  logic                           block_from_mc_refresh,
  input  logic [NUM_BANKS-1:0]           bank_open_mask,
  input  logic [NUM_BANKS*ROW_WIDTH-1:0] bank_open_row,
  periodic_read_scheduler_if.master      inj,
  output logic                           sweep_done,
  output logic [CNT_WIDTH-1:0]           issued_count,
  output logic                           busy
`ifdef PER_RD_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_COUNT     = 2'd1;
  localparam logic [1:0] S_REQ       = 2'd2;
  localparam logic [1:0] S_WAIT_DROP = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [INTERVAL_WIDTH-1:0] cnt_q, cnt_d;
  logic [BANK_PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic                      req_q, req_d;
  logic [NUM_BANKS-1:0]      sel_q, sel_d;
  logic                      open_q, open_d;
  logic [ROW_WIDTH-1:0]      row_q, row_d;
  logic                      sweep_q, sweep_d;
  logic [CNT_WIDTH-1:0]      issued_q, issued_d;
  logic                      busy_q, busy_d;

  logic arm;
  logic accept;
  logic timeout_hit;

  assign arm    = enable && (cfg_interval != '0);
  // Only the bank currently being served can complete the handshake.
  assign accept = inj.per_rd_accept[ptr_q];

`ifdef PER_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            timeout_q, timeout_d;
  assign timeout_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    req_d    = req_q;
    sel_d    = sel_q;
    open_d   = open_q;
    row_d    = row_q;
    sweep_d  = 1'b0;
    issued_d = issued_q;
`ifdef PER_RD_TIMEOUT_EN
    to_d      = to_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_COUNT;
          cnt_d   = cfg_interval - INTERVAL_WIDTH'(1);
        end
      end
      S_COUNT: begin
        if (!arm) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!block_from_mc_refresh) begin
          if (cnt_q == '0) begin
            // Request fields are snapshotted here and held for the whole request.
            state_d = S_REQ;
            req_d   = 1'b1;
            sel_d   = NUM_BANKS'(1) << ptr_q;
            open_d  = bank_open_mask[ptr_q];
            row_d   = bank_open_mask[ptr_q] ?
                      bank_open_row[int'(ptr_q)*ROW_WIDTH +: ROW_WIDTH] : '0;
`ifdef PER_RD_TIMEOUT_EN
            to_d    = '0;
`endif
          end else begin
            cnt_d = cnt_q - INTERVAL_WIDTH'(1);
          end
        end
      end
      S_REQ: begin
        // Neither enable nor refresh withdraws an outstanding request.
        if (accept || timeout_hit) begin
          state_d = S_WAIT_DROP;
          req_d   = 1'b0;
          sel_d   = '0;
          ptr_d   = ptr_q + BANK_PTR_WIDTH'(1);
          sweep_d = (ptr_q == BANK_PTR_WIDTH'(NUM_BANKS - 1));
          if (accept) begin
            if (issued_q != '1) issued_d = issued_q + CNT_WIDTH'(1);
          end
`ifdef PER_RD_TIMEOUT_EN
          else begin
            timeout_d = 1'b1;
          end
`endif
        end
`ifdef PER_RD_TIMEOUT_EN
        else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      S_WAIT_DROP: begin
        // One guaranteed low cycle on per_rd_req before the next countdown.
        if (arm) begin
          state_d = S_COUNT;
          cnt_d   = cfg_interval - INTERVAL_WIDTH'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      req_q    <= 1'b0;
      sel_q    <= '0;
      open_q   <= 1'b0;
      row_q    <= '0;
      sweep_q  <= 1'b0;
      issued_q <= '0;
      busy_q   <= 1'b0;
`ifdef PER_RD_TIMEOUT_EN
      to_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      open_q   <= open_d;
      row_q    <= row_d;
      sweep_q  <= sweep_d;
      issued_q <= issued_d;
      busy_q   <= busy_d;
`ifdef PER_RD_TIMEOUT_EN
      to_q      <= to_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign inj.per_rd_req    = req_q;
  assign inj.inject_select = sel_q;
  assign inj.inject_open   = open_q;
  assign inj.inject_row    = row_q;
  assign sweep_done        = sweep_q;
  assign issued_count      = issued_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_periodic_read_scheduler.sv
// tb/tb_periodic_read_scheduler.sv - randomized bench for periodic_read_scheduler
module tb_periodic_read_scheduler;
  localparam int NB = 16;
  localparam int RW = 18;
  localparam int IW = 16;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             refresh;
  logic [IW-1:0]    cfg;
  logic [NB-1:0]    mask;
  logic [NB*RW-1:0] rows_flat;
  logic [RW-1:0]    rows_arr [NB];
  logic             sweep_done;
  logic [CW-1:0]    issued;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ptr;
  int exp_issued;

  periodic_read_scheduler_if #(.NUM_BANKS(NB), .ROW_WIDTH(RW)) bus ();

`ifdef PER_RD_TIMEOUT_EN
  logic timeout_err;
`endif

  periodic_read_scheduler dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .enable                (enable),
    .cfg_interval          (cfg),
    .block_from_mc_refresh (refresh),
    .bank_open_mask        (mask),
    .bank_open_row         (rows_flat),
    .inj                   (bus),
    .sweep_done            (sweep_done),
    .issued_count          (issued),
    .busy                  (busy)
`ifdef PER_RD_TIMEOUT_EN
    ,
    .timeout_err           (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic randomize_banks();
    mask = NB'($urandom);
    for (int i = 0; i < NB; i++) begin
      rows_arr[i] = RW'($urandom);
      rows_flat[i*RW +: RW] = rows_arr[i];
    end
  endtask

  // One clock edge; sweep_done is pulsed only on the accept that wraps the pointer.
  task automatic step(input bit exp_sweep);
    @(posedge clk);
    #1;
    check("sweep_done", sweep_done, exp_sweep);
  endtask

  task automatic run_trial(input int t);
    int n, free, target, guard, dly, b;
    bit abort, drop_en, exp_open;
    logic [NB-1:0] exp_sel;
    logic [RW-1:0] exp_row;

    n       = (t == 0) ? 10 : $urandom_range(1, 12);
    abort   = (t > 2) && ($urandom_range(0, 9) == 0);
    drop_en = (t > 0) && ($urandom_range(0, 4) == 0);

    // Entry edge: from IDLE or WAIT_DROP this edge starts the countdown.
    cfg = IW'(n);
    enable = 1'b1;
    refresh = 1'b0;
    bus.per_rd_accept = NB'($urandom);
    step(1'b0);
    bus.per_rd_accept = '0;
    check("busy_count", busy, 1'b1);
    check("req_count", bus.per_rd_req, 1'b0);
    check("issued_count", issued, exp_issued);

    // The request must appear right after the n-th refresh-free edge.
    target = abort ? $urandom_range(0, n - 1) : n;
    free = 0;
    guard = 0;
    while (free < target && guard < 400) begin
      refresh = (t == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      randomize_banks();
      bus.per_rd_accept = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      step(1'b0);
      bus.per_rd_accept = '0;
      if (!refresh) free++;
      guard++;
      check("req_timing", bus.per_rd_req, (free == n));
    end
    if (free < target) begin
      check("countdown_budget", free, target);
      return;
    end

    if (abort) begin
      if ($urandom_range(0, 1) == 1) enable = 1'b0;
      else cfg = '0;
      refresh = 1'(($urandom_range(0, 1)));
      step(1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_req", bus.per_rd_req, 1'b0);
      return;
    end

    exp_sel  = NB'(1) << exp_ptr;
    exp_open = mask[exp_ptr];
    exp_row  = exp_open ? rows_arr[exp_ptr] : '0;
    check("req_up", bus.per_rd_req, 1'b1);
    check("select", bus.inject_select, exp_sel);
    check("open", bus.inject_open, exp_open);
    check("row", bus.inject_row, exp_row);
    check("busy_req", busy, 1'b1);

    dly = $urandom_range(0, 4);
    for (int i = 0; i < dly; i++) begin
      randomize_banks();
      refresh = 1'(($urandom_range(0, 1)));
      if (drop_en) enable = 1'b0;
      b = $urandom_range(0, NB - 1);
      bus.per_rd_accept = (b != exp_ptr) ? (NB'(1) << b) : '0;
      step(1'b0);
      check("req_hold", bus.per_rd_req, 1'b1);
      check("select_hold", bus.inject_select, exp_sel);
      check("open_hold", bus.inject_open, exp_open);
      check("row_hold", bus.inject_row, exp_row);
    end

    bus.per_rd_accept = NB'($urandom) | exp_sel;
    exp_issued = (exp_issued == 65535) ? 65535 : exp_issued + 1;
    step(exp_ptr == NB - 1);
    bus.per_rd_accept = '0;
    check("req_drop", bus.per_rd_req, 1'b0);
    check("select_drop", bus.inject_select, '0);
    check("issued_after_accept", issued, exp_issued);
    check("busy_wait_drop", busy, 1'b1);
    exp_ptr = (exp_ptr + 1) % NB;

    if (drop_en || ($urandom_range(0, 5) == 0)) begin
      enable = 1'b0;
      refresh = 1'(($urandom_range(0, 1)));
      bus.per_rd_accept = NB'($urandom);
      step(1'b0);
      bus.per_rd_accept = '0;
      check("busy_idle", busy, 1'b0);
      check("req_idle", bus.per_rd_req, 1'b0);
      check("issued_idle", issued, exp_issued);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    refresh = 1'b0;
    cfg = '0;
    bus.per_rd_accept = '0;
    randomize_banks();
    step(1'b0);
    step(1'b0);
    check("rst_req", bus.per_rd_req, 1'b0);
    check("rst_select", bus.inject_select, '0);
    check("rst_open", bus.inject_open, 1'b0);
    check("rst_row", bus.inject_row, '0);
    check("rst_issued", issued, '0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step(1'b0);
    check("idle_busy", busy, 1'b0);

    exp_ptr = 0;
    exp_issued = 0;
    for (int t = 0; t < 40; t++) run_trial(t);

    // Reset in the middle of a request, with the matching accept arriving.
    cfg = 16'd2;
    enable = 1'b1;
    refresh = 1'b0;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("pre_reset_req", bus.per_rd_req, 1'b1);
    rst_n = 1'b0;
    bus.per_rd_accept = NB'(1) << exp_ptr;
    step(1'b0);
    check("midrst_req", bus.per_rd_req, 1'b0);
    check("midrst_select", bus.inject_select, '0);
    check("midrst_issued", issued, '0);
    check("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step(1'b0);
    bus.per_rd_accept = '0;
    check("late_accept_issued", issued, '0);
    step(1'b0);
    step(1'b0);
    check("post_rst_req", bus.per_rd_req, 1'b1);
    check("post_rst_select", bus.inject_select, 16'h0001);
    bus.per_rd_accept = 16'h0001;
    step(1'b0);
    bus.per_rd_accept = '0;
    check("post_rst_issued", issued, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
